// File: rtl/pic_irq_sequencer.sv
// 8259-style interrupt sequencer: IRR capture, fully nested priority resolution,
// two-pulse INTA acknowledge, ISR set/clear (EOI, specific EOI, AEOI) and rotation.

module pic_irr_cell (
    input  logic clk,
    input  logic reset,
    input  logic ir,
    input  logic ir_prev,
    input  logic ltim,
    input  logic ack_clr,
    output logic irr
);
    // acknowledge clear beats both level reload and edge capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                irr <= 1'b0;
        else if (ack_clr)         irr <= 1'b0;
        else if (ltim)            irr <= ir;
        else if (ir && !ir_prev)  irr <= 1'b1;
    end
endmodule

module pic_irq_sequencer #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] ir_in,
    input  logic             ltim,
    input  logic             aeoi,
    input  logic             rotate_aeoi,
    input  logic [N_IRQ-1:0] imr,
    input  logic [4:0]       vector_base,
    input  logic             inta_n,
    input  logic             eoi_valid,
    input  logic             eoi_specific,
    input  logic [ID_W-1:0]  eoi_id,
    input  logic             rotate_on_eoi,
    output logic             int_out,
    output logic [7:0]       vec_out,
    output logic             vec_valid,
    output logic [N_IRQ-1:0] irr,
    output logic [N_IRQ-1:0] isr,
    output logic [ID_W-1:0]  hp_id,
    output logic [ID_W-1:0]  highest_isr_id
);
    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    localparam logic [ID_W-1:0] SPURIOUS_ID = '1;

    state_t            state, state_nxt;
    logic [N_IRQ-1:0]  ir_prev;
    logic              inta_prev;
    logic [ID_W-1:0]   ack_id;
    logic              spurious;

    logic              inta_fall, inta_rise;
    logic              ack_start, vec_load, ack_done;

    logic [N_IRQ-1:0]   req;
    logic [2*N_IRQ-1:0] req_sh, isr_sh;
    logic [N_IRQ-1:0]   req_rot, isr_rot;
    logic [ID_W-1:0]    req_r, isr_r;
    logic               req_any, isr_any;
    logic               cand_valid;
    logic [ID_W-1:0]    cand_id;

    logic [N_IRQ-1:0]  ack_clr, aeoi_clr, eoi_clr, isr_nxt;
    logic [ID_W-1:0]   eoi_target, hp_nxt;
    logic              eoi_hit, aeoi_fire;

    assign inta_fall = inta_prev & ~inta_n;
    assign inta_rise = ~inta_prev & inta_n;

    genvar g;
    generate
        for (g = 0; g < N_IRQ; g++) begin : g_irr
            pic_irr_cell u_irr (
                .clk     (clk),
                .reset   (reset),
                .ir      (ir_in[g]),
                .ir_prev (ir_prev[g]),
                .ltim    (ltim),
                .ack_clr (ack_clr[g]),
                .irr     (irr[g])
            );
        end
    endgenerate

    // Rotate so that bit 0 is the current highest-priority line; the lowest
    // set bit of the rotated vector is then the winner's rank.
    assign req     = irr & ~imr;
    assign req_sh  = {req, req} >> hp_id;
    assign isr_sh  = {isr, isr} >> hp_id;
    assign req_rot = req_sh[N_IRQ-1:0];
    assign isr_rot = isr_sh[N_IRQ-1:0];
    assign req_any = |req_rot;
    assign isr_any = |isr_rot;

    always_comb begin
        req_r = '0;
        isr_r = '0;
        for (int j = N_IRQ - 1; j >= 0; j--) begin
            if (req_rot[j]) req_r = ID_W'(j);
            if (isr_rot[j]) isr_r = ID_W'(j);
        end
    end

    // fully nested: a request must strictly outrank every in-service level
    assign cand_valid     = req_any && (!isr_any || (req_r < isr_r));
    assign cand_id        = req_r + hp_id;
    assign highest_isr_id = isr_any ? (isr_r + hp_id) : '0;

    always_comb begin
        state_nxt = state;
        ack_start = 1'b0;
        vec_load  = 1'b0;
        ack_done  = 1'b0;
        case (state)
            IDLE: if (inta_fall) begin
                ack_start = 1'b1;
                state_nxt = ACK1;
            end
            ACK1: if (inta_fall) begin
                vec_load  = 1'b1;
                state_nxt = ACK2;
            end
            ACK2: if (inta_rise) begin
                ack_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ack_clr    = (ack_start && cand_valid) ? (N_IRQ'(1) << cand_id) : '0;
    assign aeoi_fire  = ack_done && aeoi && !spurious;
    assign aeoi_clr   = aeoi_fire ? (N_IRQ'(1) << ack_id) : '0;
    assign eoi_target = eoi_specific ? eoi_id : highest_isr_id;
    assign eoi_hit    = eoi_valid && isr[eoi_target];
    assign eoi_clr    = eoi_hit ? (N_IRQ'(1) << eoi_target) : '0;
    assign isr_nxt    = (isr | ack_clr) & ~(aeoi_clr | eoi_clr);

    // EOI rotation overrides AEOI rotation when both land in one cycle
    always_comb begin
        hp_nxt = hp_id;
        if (eoi_hit && rotate_on_eoi)      hp_nxt = eoi_target + ID_W'(1);
        else if (aeoi_fire && rotate_aeoi) hp_nxt = ack_id + ID_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            inta_prev <= 1'b1;
            ir_prev   <= '0;
            isr       <= '0;
            hp_id     <= '0;
            int_out   <= 1'b0;
            ack_id    <= '0;
            spurious  <= 1'b0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            inta_prev <= inta_n;
            ir_prev   <= ir_in;
            isr       <= isr_nxt;
            hp_id     <= hp_nxt;
            int_out   <= (state_nxt == IDLE) && cand_valid;
            if (ack_start) begin
                ack_id   <= cand_valid ? cand_id : SPURIOUS_ID;
                spurious <= !cand_valid;
            end
            if (vec_load) begin
                vec_out   <= {vector_base, ack_id};
                vec_valid <= 1'b1;
            end else if (ack_done) begin
                vec_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pic_irq_sequencer.sv
// Scoreboard bench for pic_irq_sequencer: transaction-level reference model,
// expected vectors queued at INTA issue and checked by an independent monitor.

module tb_pic_irq_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir_in;
    logic       ltim, aeoi, rotate_aeoi;
    logic [7:0] imr;
    logic [4:0] vector_base;
    logic       inta_n, eoi_valid, eoi_specific, rotate_on_eoi;
    logic [2:0] eoi_id;
    logic       int_out, vec_valid;
    logic [7:0] vec_out, irr, isr;
    logic [2:0] hp_id, highest_isr_id;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_irr, m_isr;
    logic [2:0] m_hp;
    logic [7:0] exp_q[$];
    logic       vv_prev = 1'b0;

    pic_irq_sequencer dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .ltim(ltim), .aeoi(aeoi),
        .rotate_aeoi(rotate_aeoi), .imr(imr), .vector_base(vector_base),
        .inta_n(inta_n), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
        .eoi_id(eoi_id), .rotate_on_eoi(rotate_on_eoi), .int_out(int_out),
        .vec_out(vec_out), .vec_valid(vec_valid), .irr(irr), .isr(isr),
        .hp_id(hp_id), .highest_isr_id(highest_isr_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Walk the circular priority order from m_hp; first in-service level blocks.
    function automatic int m_cand();
        int id;
        for (int k = 0; k < 8; k++) begin
            id = (int'(m_hp) + k) % 8;
            if (m_isr[id]) return -1;
            if (m_irr[id] && !imr[id]) return id;
        end
        return -1;
    endfunction

    function automatic int m_hisr();
        int id;
        for (int k = 0; k < 8; k++) begin
            id = (int'(m_hp) + k) % 8;
            if (m_isr[id]) return id;
        end
        return 0;
    endfunction

    // Monitor: every new vector presented must match the oldest queued one.
    always @(negedge clk) begin
        if (vec_valid && !vv_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vec_unexpected got=%0h want=none", vec_out);
            end else begin
                chk("vec_out", int'(vec_out), int'(exp_q.pop_front()));
            end
        end
        vv_prev <= vec_valid;
    end

    task automatic compare_all(input string tag);
        if (ltim) m_irr = ir_in;
        chk({tag, ".irr"}, int'(irr), int'(m_irr));
        chk({tag, ".isr"}, int'(isr), int'(m_isr));
        chk({tag, ".hp_id"}, int'(hp_id), int'(m_hp));
        chk({tag, ".hisr"}, int'(highest_isr_id), m_hisr());
        chk({tag, ".int_out"}, int'(int_out), int'(m_cand() >= 0));
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] bits);
        @(negedge clk) ir_in = bits;
        @(negedge clk) ir_in = 8'h00;
        m_irr = m_irr | bits;
    endtask

    task automatic do_ack();
        int c;
        logic [2:0] aid;
        bit spur;
        c = m_cand();
        spur = (c < 0);
        aid = spur ? 3'd7 : 3'(c);
        exp_q.push_back({vector_base, aid});
        @(negedge clk) inta_n = 1'b0;
        @(negedge clk);
        if (!spur) begin
            m_isr[aid] = 1'b1;
            m_irr[aid] = 1'b0;
        end
        chk("int_out_during_ack", int'(int_out), 0);
        inta_n = 1'b1;
        settle(2);
        inta_n = 1'b0;
        settle(2);
        chk("vec_valid_hold", int'(vec_valid), 1);
        inta_n = 1'b1;
        @(negedge clk);
        chk("vec_valid_drop", int'(vec_valid), 0);
        if (aeoi && !spur) begin
            m_isr[aid] = 1'b0;
            if (rotate_aeoi) m_hp = aid + 3'd1;
        end
        settle(2);
    endtask

    task automatic do_eoi(input bit spec, input logic [2:0] id, input bit rot);
        int t;
        t = spec ? int'(id) : m_hisr();
        if ((spec || m_isr != 8'h00) && m_isr[t]) begin
            m_isr[t] = 1'b0;
            if (rot) m_hp = 3'(t + 1);
        end
        @(negedge clk);
        eoi_valid = 1'b1; eoi_specific = spec; eoi_id = id; rotate_on_eoi = rot;
        @(negedge clk);
        eoi_valid = 1'b0; eoi_specific = 1'b0; rotate_on_eoi = 1'b0;
        settle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ir_in = 8'h00; ltim = 1'b0; aeoi = 1'b0; rotate_aeoi = 1'b0;
        imr = 8'h00; vector_base = 5'h08; inta_n = 1'b1; eoi_valid = 1'b0;
        eoi_specific = 1'b0; eoi_id = 3'd0; rotate_on_eoi = 1'b0;
        m_irr = 8'h00; m_isr = 8'h00; m_hp = 3'd0;
        settle(3);
        chk("rst.irr", int'(irr), 0);
        chk("rst.isr", int'(isr), 0);
        chk("rst.hp_id", int'(hp_id), 0);
        chk("rst.int_out", int'(int_out), 0);
        chk("rst.vec_valid", int'(vec_valid), 0);
        chk("rst.vec_out", int'(vec_out), 0);
        chk("rst.hisr", int'(highest_isr_id), 0);
        reset = 1'b0;
        settle(2);

        // single edge request, full acknowledge
        pulse(8'h08);
        @(negedge clk);
        compare_all("t1_req");
        do_ack();
        compare_all("t1_ack");
        do_eoi(1'b0, 3'd0, 1'b0);
        compare_all("t1_eoi");

        // simultaneous IR2/IR5, IR2 first
        pulse(8'h24); settle(2); compare_all("t2_req");
        do_ack(); compare_all("t2_ack2");
        do_eoi(1'b0, 3'd0, 1'b0); compare_all("t2_eoi");
        do_ack(); compare_all("t2_ack5");
        do_eoi(1'b0, 3'd0, 1'b0);

        // nesting: IR6 blocked by IR5, IR1 preempts
        pulse(8'h20); settle(2); do_ack();
        pulse(8'h40); settle(2); compare_all("t3_blocked");
        pulse(8'h02); settle(2); compare_all("t3_nest");
        do_ack(); compare_all("t3_isr22");
        do_eoi(1'b0, 3'd0, 1'b0); do_eoi(1'b0, 3'd0, 1'b0);
        do_ack(); do_eoi(1'b0, 3'd0, 1'b0); compare_all("t3_drain");

        // AEOI with rotation
        aeoi = 1'b1; rotate_aeoi = 1'b1;
        pulse(8'h10); settle(2); do_ack(); compare_all("t4_aeoi");
        pulse(8'h50); settle(2); do_ack(); compare_all("t4_ir6");
        do_ack(); compare_all("t4_ir4");
        aeoi = 1'b0; rotate_aeoi = 1'b0;

        // level mode, masking, spurious acknowledge
        ltim = 1'b1; imr = 8'h01;
        @(negedge clk) ir_in = 8'h01;
        settle(3); compare_all("t5_masked");
        imr = 8'h00; settle(3); compare_all("t5_unmasked");
        ir_in = 8'h00; settle(3); compare_all("t5_dropped");
        do_ack(); compare_all("t5_spurious");
        ltim = 1'b0; settle(2);

        // reset in the middle of an acknowledge
        pulse(8'h01); settle(2);
        @(negedge clk) inta_n = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst.isr", int'(isr), 0);
        chk("mid_rst.irr", int'(irr), 0);
        chk("mid_rst.int_out", int'(int_out), 0);
        chk("mid_rst.vec_valid", int'(vec_valid), 0);
        inta_n = 1'b1;
        m_irr = 8'h00; m_isr = 8'h00; m_hp = 3'd0;
        settle(2);
        reset = 1'b0;
        settle(2);
        compare_all("t6_after_rst");

        // specific EOI on nested ISR = 06
        pulse(8'h04); settle(2); do_ack();
        pulse(8'h02); settle(2); do_ack(); compare_all("t6_isr06");
        do_eoi(1'b1, 3'd2, 1'b0); compare_all("t6_spec_eoi");
        do_eoi(1'b0, 3'd0, 1'b1); compare_all("t6_rot_eoi");

        // randomized edge-mode traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: pulse(8'($urandom_range(1, 255)));
                1: imr = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
                2: begin
                    aeoi = 1'($urandom_range(0, 1));
                    rotate_aeoi = 1'($urandom_range(0, 1));
                    vector_base = 5'($urandom_range(0, 31));
                    do_ack();
                end
                default: do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                                1'($urandom_range(0, 1)));
            endcase
            settle(2);
            compare_all("rand");
        end

        settle(2);
        chk("vec_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
